// File: rtl/delay_timer_multi_pkg.sv
// Shared types for the multi-channel delay timer: channel state encoding
// and the per-channel mode bit meaning.
package delay_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/delay_timer_multi_if.sv
// Control/status bundle of the multi-channel delay timer; the register
// block drives the master side, the timer sits on the slave side.
interface delay_timer_multi_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CBITS = 15
);
   logic [NCH-1:0]   en;
   logic [NCH-1:0]   mode;
   logic [NCH-1:0]   load;
   logic [CBITS-1:0] period;
   logic [NCH-1:0]   ack;
   logic [NCH-1:0]   clr_err;
   logic [NCH-1:0]   sig;
   logic [NCH-1:0]   pend;
   logic [NCH-1:0]   err;
   logic [NCH-1:0]   flg;

   modport master (
      output en, mode, load, period, ack, clr_err,
      input  sig, pend, err, flg
   );

   modport slave (
      input  en, mode, load, period, ack, clr_err,
      output sig, pend, err, flg
   );
endinterface

// File: rtl/delay_timer_multi_ch.sv
// One timer channel: IDLE/RUN/DONE control, terminal counter, loadable
// limit and the pend/err tick handshake. All outputs come straight from flops.
module delay_timer_ch
   import delay_timer_pkg::*;
#(
   parameter int unsigned CBITS     = 15,
   parameter int unsigned N_DEFAULT = 20000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic [CBITS-1:0] period_i,
   input  logic             ack_i,
   input  logic             clr_err_i,
   output logic             sig_o,
   output logic             pend_o,
   output logic             err_o,
   output logic             flg_o
);

   localparam logic [CBITS-1:0] LIMIT_RST = CBITS'(N_DEFAULT);

   state_e           state_q, state_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] limit_q, limit_d;
   logic             sig_q, sig_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;
   logic             flg_q;
   logic             term;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      limit_d = load_i ? period_i : limit_q;
      // Disable and load both pre-empt a terminal count on the same cycle.
      term    = (state_q == RUN) && en_i && !load_i && (cnt_q == limit_q);
      sig_d   = term;
      pend_d  = term ? 1'b1 : (ack_i ? 1'b0 : pend_q);
      err_d   = (term && pend_q && !ack_i) ? 1'b1 : (clr_err_i ? 1'b0 : err_q);

      if (!en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = RUN;
               cnt_d   = '0;
            end
            RUN: begin
               if (load_i) begin
                  cnt_d = '0;
               end else if (term) begin
                  cnt_d   = '0;
                  state_d = (mode_i == MODE_ONESHOT) ? DONE : RUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: begin
               cnt_d = '0;
               if (load_i) state_d = RUN;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         limit_q <= LIMIT_RST;
         sig_q   <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         flg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         limit_q <= limit_d;
         sig_q   <= sig_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         flg_q   <= (state_d == RUN);
      end
   end

   assign sig_o  = sig_q;
   assign pend_o = pend_q;
   assign err_o  = err_q;
   assign flg_o  = flg_q;

endmodule

// File: rtl/delay_timer_multi.sv
// Multi-channel programmable delay timer: NCH independent channels sharing
// one broadcast period bus, each with its own enable, mode and handshake.
module delay_timer_multi #(
   parameter int unsigned NCH       = 4,
   parameter int unsigned CBITS     = 15,
   parameter int unsigned N_DEFAULT = 20000
) (
   input logic               clk,
   input logic               rst_n,
   delay_timer_multi_if.slave bus
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      delay_timer_ch #(
         .CBITS     (CBITS),
         .N_DEFAULT (N_DEFAULT)
      ) u_ch (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .en_i      (bus.en[i]),
         .mode_i    (bus.mode[i]),
         .load_i    (bus.load[i]),
         .period_i  (bus.period),
         .ack_i     (bus.ack[i]),
         .clr_err_i (bus.clr_err[i]),
         .sig_o     (bus.sig[i]),
         .pend_o    (bus.pend[i]),
         .err_o     (bus.err[i]),
         .flg_o     (bus.flg[i])
      );
   end

endmodule

// File: tb/tb_delay_timer_multi.sv
// Scoreboard bench for delay_timer_multi: a deadline-based reference model
// predicts each cycle's outputs, a separate monitor pops and compares them.
module tb_delay_timer_multi;

   localparam int NCH   = 4;
   localparam int CBITS = 15;
   localparam int NDEF  = 20000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   delay_timer_multi_if #(.NCH(NCH), .CBITS(CBITS)) bus ();

   delay_timer_multi #(
      .NCH       (NCH),
      .CBITS     (CBITS),
      .N_DEFAULT (NDEF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [NCH-1:0] sig;
      logic [NCH-1:0] pend;
      logic [NCH-1:0] err;
      logic [NCH-1:0] flg;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: per channel, 0 = idle, 1 = armed, 2 = one-shot spent;
   // m_next is the absolute edge number at which the next tick fires.
   int m_st   [NCH];
   int m_lim  [NCH];
   int m_next [NCH];
   bit m_pend [NCH];
   bit m_err  [NCH];
   int edge_n = 0;

   logic [NCH-1:0]   en_v, mode_v, load_v, ack_v, clr_v;
   logic [CBITS-1:0] per_v;
   bit               rst_v;

   task automatic check(input string name, input logic [NCH-1:0] act,
                        input logic [NCH-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
      end
   endtask

   // Apply one cycle of stimulus at the falling edge and predict the outputs
   // that the following rising edge must produce.
   task automatic step();
      exp_t e;
      @(negedge clk);
      rst_n       = rst_v;
      bus.en      = en_v;
      bus.mode    = mode_v;
      bus.load    = load_v;
      bus.period  = per_v;
      bus.ack     = ack_v;
      bus.clr_err = clr_v;
      edge_n++;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         bit tick;
         int nl;
         if (!rst_v) begin
            m_st[i] = 0; m_lim[i] = NDEF; m_pend[i] = 0; m_err[i] = 0;
         end else begin
            nl   = load_v[i] ? int'(per_v) : m_lim[i];
            tick = (m_st[i] == 1) && en_v[i] && !load_v[i] && (edge_n == m_next[i]);
            e.sig[i] = tick;
            if (tick && m_pend[i] && !ack_v[i]) m_err[i] = 1;
            else if (clr_v[i])                  m_err[i] = 0;
            if (tick)          m_pend[i] = 1;
            else if (ack_v[i]) m_pend[i] = 0;
            if (!en_v[i]) m_st[i] = 0;
            else if (m_st[i] == 0 || load_v[i]) begin
               m_st[i] = 1; m_next[i] = edge_n + nl + 1;
            end else if (tick) begin
               if (mode_v[i]) m_st[i] = 2;
               else           m_next[i] = edge_n + nl + 1;
            end
            m_lim[i] = nl;
         end
         e.pend[i] = m_pend[i];
         e.err[i]  = m_err[i];
         e.flg[i]  = (m_st[i] == 1);
      end
      sb.push_back(e);
      load_v = '0;
      ack_v  = '0;
      clr_v  = '0;
   endtask

   // Step until the upcoming edge is channel ch's terminal edge.
   task automatic wait_term(input int ch);
      int k = 0;
      while (!(m_st[ch] == 1 && m_next[ch] == edge_n + 1) && k < 200) begin
         step();
         k++;
      end
      if (k >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_term ch=%0d actual=timeout required=terminal", ch);
      end
   endtask

   initial begin : monitor
      exp_t me;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            me = sb.pop_front();
            check("sig",  bus.sig,  me.sig);
            check("pend", bus.pend, me.pend);
            check("err",  bus.err,  me.err);
            check("flg",  bus.flg,  me.flg);
         end
      end
   end

   initial begin : stim
      rst_n = 1'b0;
      bus.en = '0; bus.mode = '0; bus.load = '0; bus.period = '0;
      bus.ack = '0; bus.clr_err = '0;
      en_v = '0; mode_v = '0; load_v = '0; ack_v = '0; clr_v = '0;
      per_v = '0; rst_v = 1'b0;
      repeat (3) step();
      rst_v = 1'b1;
      step();

      // ch0 runs periodic on the default limit for the whole first phase
      en_v[0] = 1'b1;

      // ch1 one-shot, limit 3, then re-armed by a second load
      en_v[1] = 1'b1; mode_v[1] = 1'b1; per_v = 15'd3; load_v[1] = 1'b1;
      step();
      repeat (8) step();
      per_v = 15'd3; load_v[1] = 1'b1;
      step();
      repeat (8) step();

      // ch2 limit 0: tick every cycle, overruns pile up, clear loses to set
      en_v[2] = 1'b1; per_v = 15'd0; load_v[2] = 1'b1;
      step();
      repeat (5) step();
      clr_v[2] = 1'b1;
      step();
      repeat (2) step();
      en_v[2] = 1'b0; clr_v[2] = 1'b1;
      step();
      step();

      // ch3 limit 5: disable on the terminal edge, then load on a terminal edge
      en_v[3] = 1'b1; per_v = 15'd5; load_v[3] = 1'b1;
      step();
      wait_term(3);
      en_v[3] = 1'b0;
      step();
      en_v[3] = 1'b1;
      step();
      wait_term(3);
      per_v = 15'd7; load_v[3] = 1'b1;
      step();
      repeat (12) step();

      // ch1 periodic limit 3: ack lands exactly on the next terminal edge
      mode_v[1] = 1'b0; per_v = 15'd3; load_v[1] = 1'b1;
      ack_v[1] = 1'b1; clr_v[1] = 1'b1;
      step();
      wait_term(1);
      step();
      wait_term(1);
      ack_v[1] = 1'b1;
      step();
      repeat (3) step();

      // Random traffic on ch1..3 while ch0 completes two long periods
      repeat (41000) begin
         for (int i = 1; i < NCH; i++) begin
            en_v[i] = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 31) == 0) mode_v[i] = ~mode_v[i];
            if ($urandom_range(0, 23) == 0) load_v[i] = 1'b1;
            ack_v[i] = ($urandom_range(0, 3) == 0);
            clr_v[i] = ($urandom_range(0, 15) == 0);
         end
         ack_v[0] = ($urandom_range(0, 49) == 0);
         per_v = 15'($urandom_range(0, 15));
         step();
      end

      // Asynchronous reset mid-count, away from any clock edge
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_sig",  bus.sig,  '0);
      check("rst_pend", bus.pend, '0);
      check("rst_err",  bus.err,  '0);
      check("rst_flg",  bus.flg,  '0);
      rst_v = 1'b0;
      step();
      step();
      rst_v = 1'b1;
      en_v = '1; mode_v = '0;
      repeat (20050) begin
         ack_v = '0;
         for (int i = 0; i < NCH; i++) ack_v[i] = ($urandom_range(0, 49) == 0);
         step();
      end

      @(posedge clk);
      #2;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
